i2s_receiver: RTL
=================

Name: i2s_receiver

Overview:
- I2S slave receiver. Captures serial audio from an external ADC/codec (sck, ws, sd, all driven externally) and delivers stereo samples as an AXI4-Stream master.
- Output format matches what i2s_transmitter consumes: left word with TLAST=0, then right word with TLAST=1. It is the upstream source of the capture → process → playback chain.
- All logic runs in one AXI clock domain. The I2S lines are oversampled; no logic is clocked by sck.

Parameters:
- DATA_WIDTH, 32, width of TDATA and of the captured word (received bits are left-justified into it).

Ports:
- M_AXIS_ACLK  input  1  system clock; must be ≥ 8× sck frequency.
- M_AXIS_ARESETN  input  1  asynchronous active-low reset.
- M_AXIS_TVALID  output  1  sample valid.
- M_AXIS_TDATA  output  DATA_WIDTH  sample, MSB-first aligned.
- M_AXIS_TLAST  output  1  0 = left word, 1 = right word.
- M_AXIS_TREADY  input  1  downstream ready.
- sck  input  1  I2S bit clock (asynchronous).
- ws  input  1  word select: 0 = left, 1 = right (asynchronous).
- sd  input  1  serial data (asynchronous).
- clear_overrun  input  1  single-cycle pulse; clears overrun.
- overrun  output  1  sticky flag: a stereo pair was dropped.

Behaviour:
- Reset: all outputs and internal registers clear asynchronously. TVALID=0, TLAST=0, TDATA=0, overrun=0, FIFO empty, word tracker unarmed.
- Input sampling:
  - sck, ws and sd each pass through a 2-FF synchronizer of identical depth, so the three stay mutually aligned.
  - A third register on synced sck detects rise = (prev,cur)==01.
  - All actions below occur only in ACLK cycles where rise=1.
- Word framing (standard I2S, data valid one bit after a ws change). At each rise, with ws_s/sd_s the synced values:
  - If count < DATA_WIDTH: shreg[DATA_WIDTH-1-count] <= sd_s and count++. Otherwise count saturates at DATA_WIDTH and the bit is ignored.
  - If ws_s != ws_prev, the current word ends and includes this bit, which is the LSB of the old channel.
    - Word = shreg, including the just-written bit; unwritten low bits are 0.
    - Channel = ws_prev.
    - The word is emitted only if armed=1.
    - Then shreg<=0, count<=0, armed<=1, ws_prev<=ws_s.
- Start-up alignment:
  - The first ws edge after reset only arms the tracker; the partial word before it is discarded.
  - Streaming starts with a left word only. A right word that completes with no accepted left pending is discarded.
- Output buffer: 2-entry FIFO of {TLAST, data}, presented at the M_AXIS_* outputs.
  - Pop on TVALID&&TREADY.
  - TVALID=!empty, with TDATA/TLAST from the head entry. Once TVALID=1, TDATA and TLAST hold stable until the handshake.
- Pair-granular overrun:
  - A completing left word is accepted only if the FIFO is empty after this cycle's pop. Otherwise both it and the following right word are dropped, and overrun<=1.
  - A right word is accepted iff its left partner was accepted. Depth 2 guarantees room.
- Latency: a completed word reaches TVALID=1 one ACLK after the rise cycle that ends it.
- clear_overrun clears overrun. If a drop occurs in the same cycle, set wins.
- Longer frames: bits beyond DATA_WIDTH per channel are ignored, i.e. the upper DATA_WIDTH bits are kept.
- Shorter frames: zero-padded at the LSBs.
- Reset mid-word or mid-handshake: immediate clear. Restart follows the start-up alignment rule.
- ws changing twice with no rise between is unsupported; behaviour is undefined.

Decomposition:
- Package i2s_pkg:
  - CH_LEFT=1'b0, CH_RIGHT=1'b1.
  - SYNC_STAGES=2.
  - MIN_OVERSAMPLE=8.
  - Function clog2 for count width ($clog2(DATA_WIDTH+1)).
- One sub-module: i2s_line_sync.
  - Parameterized-width 2-FF synchronizer plus rise detect.
  - Async active-low reset.
  - Shared later with other I2S-facing blocks.

Test Plan:
1. DATA_WIDTH=32, 32 sck per channel, ACLK=16×sck, TREADY=1. Send left 0xA5A50001, right 0x12345678 after one priming frame → beats (0xA5A50001, TLAST=0) then (0x12345678, TLAST=1); overrun=0.
2. Reset released mid-right-word → first output beat is the next full left word. No beat carries partial data, and no right word is emitted first.
3. DATA_WIDTH=32, 16 sck per channel, left 0xBEEF, right 0xCAFE → 0xBEEF0000 / TLAST=0, then 0xCAFE0000 / TLAST=1.
4. DATA_WIDTH=16, 32 sck per channel, left 0x89AB_CDEF → TDATA=0x89AB. The following right word is emitted with TLAST=1.
5. TREADY=0 for 3 full stereo frames → only the first pair is buffered, with TDATA held stable; overrun=1. Then TREADY=1 → that pair emits, and the next emitted beat is a left word. A clear_overrun pulse → overrun=0.
6. ACLK-cycle checks:
   - TVALID rises exactly 1 ACLK after the word-ending rise.
   - clear_overrun coincident with a drop → overrun stays 1.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared constants and helpers for the I2S receive path.
//                Channel encoding (ws level), synchronizer depth and the
//                minimum ACLK/sck ratio the oversampling front end relies on.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Level of ws for each channel; also the TLAST encoding of that channel.
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Depth of the metastability synchronizer on every I2S line.
    localparam int SYNC_STAGES = 2;

    // ACLK must run at least this many times faster than sck so that every
    // sck high and low phase is seen by the synchronizer.
    localparam int MIN_OVERSAMPLE = 8;

    // Ceiling log2; used to size a counter that must hold values 0..N-1
    // when called with N (e.g. a bit counter 0..DATA_WIDTH uses DATA_WIDTH+1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver_if
//  Description : AXI4-Stream bundle carrying stereo samples out of the I2S
//                receiver. Left word has TLAST=0, right word TLAST=1.
//  Ports       : TVALID, TDATA[DATA_WIDTH-1:0], TLAST  (master -> slave)
//                TREADY                               (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_receiver_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  TVALID;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TLAST;
    logic                  TREADY;

    modport master (
        output TVALID,
        output TDATA,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TLAST,
        output TREADY
    );

endinterface
`default_nettype wire

// File: rtl/i2s_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_line_sync
//  Description : Oversampling front end for I2S-facing blocks. One bit-clock
//                lane and WIDTH data lanes go through the same SYNC_STAGES
//                flop chain so all lanes stay mutually aligned; a further
//                register on the clock lane yields a one-cycle rise strobe.
//  Ports       : clk          system clock
//                rst_n        asynchronous active-low reset
//                i_clk_line   asynchronous bit clock (e.g. sck)
//                i_data       asynchronous data lanes (e.g. {sd, ws})
//                o_data       synchronized data lanes
//                o_rise       1 for one clk cycle per rising edge of i_clk_line
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_line_sync
    import i2s_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clk_line,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_rise
);

    // Bit 0 of every stage is the clock lane, bits WIDTH:1 the data lanes.
    logic [WIDTH:0] r_stage [SYNC_STAGES];
    logic           r_clk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
            r_clk_prev <= 1'b0;
        end else begin
            r_stage[0] <= {i_data, i_clk_line};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_clk_prev <= r_stage[SYNC_STAGES-1][0];
        end
    end

    assign o_data = r_stage[SYNC_STAGES-1][WIDTH:1];
    assign o_rise = r_stage[SYNC_STAGES-1][0] & ~r_clk_prev;

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver
//  Description : I2S slave receiver. Oversamples sck/ws/sd in the ACLK domain,
//                frames standard I2S words (data one bit after ws change),
//                left-justifies them into DATA_WIDTH and streams stereo pairs
//                out over AXI4-Stream through a 2-entry FIFO. Pairs that do
//                not fit are dropped whole and flagged in a sticky overrun.
//  Ports       : M_AXIS_ACLK     system clock (>= 8x sck)
//                M_AXIS_ARESETN  asynchronous active-low reset
//                M_AXIS          AXI4-Stream master (TVALID/TDATA/TLAST/TREADY)
//                sck, ws, sd     asynchronous I2S lines from the codec
//                clear_overrun   single-cycle pulse, clears overrun
//                overrun         sticky: a stereo pair was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic      M_AXIS_ACLK,
    input  wire logic      M_AXIS_ARESETN,
    i2s_receiver_if.master M_AXIS,
    input  wire logic      sck,
    input  wire logic      ws,
    input  wire logic      sd,
    input  wire logic      clear_overrun,
    output logic           overrun
);

    localparam int CNT_W = clog2(DATA_WIDTH + 1);

    localparam logic [DATA_WIDTH-1:0] c_MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      c_FULL     = CNT_W'(DATA_WIDTH);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [1:0] w_lines_s;
    logic       w_rise;
    logic       w_ws_s;
    logic       w_sd_s;

    i2s_line_sync #(
        .WIDTH (2)
    ) u_line_sync (
        .clk        (M_AXIS_ACLK),
        .rst_n      (M_AXIS_ARESETN),
        .i_clk_line (sck),
        .i_data     ({sd, ws}),
        .o_data     (w_lines_s),
        .o_rise     (w_rise)
    );

    assign w_ws_s = w_lines_s[0];
    assign w_sd_s = w_lines_s[1];

    // ------------------------------------------------------------------
    // Word framing state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ws_prev;
    logic                  r_armed;
    logic                  r_left_ok;   // left of the current pair was accepted

    // ------------------------------------------------------------------
    // Output FIFO state: entries are {TLAST, data}
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_fifo_cnt;

    // ------------------------------------------------------------------
    // Combinational framing / acceptance decisions
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_edge;
    logic                  w_emit;
    logic                  w_is_left;
    logic                  w_pop;
    logic [1:0]            w_cnt_after_pop;
    logic                  w_push_left;
    logic                  w_push_right;
    logic                  w_push;
    logic                  w_drop;

    always_comb begin
        // Shifting the MSB mask by the bit count selects the bit to write;
        // once count reaches DATA_WIDTH the mask is all zeros, so surplus
        // bits of a long frame fall away without a separate compare.
        w_mask          = c_MSB_MASK >> r_count;
        w_word          = r_shreg | (w_mask & {DATA_WIDTH{w_sd_s}});
        w_edge          = w_rise && (w_ws_s != r_ws_prev);
        w_emit          = w_edge && r_armed;
        w_is_left       = (r_ws_prev == CH_LEFT);
        w_pop           = (r_fifo_cnt != 2'd0) && M_AXIS.TREADY;
        w_cnt_after_pop = r_fifo_cnt - {1'b0, w_pop};
        // A left word only starts a pair when the FIFO will be empty, which
        // leaves the second slot guaranteed for its right partner.
        w_push_left     = w_emit && w_is_left && (w_cnt_after_pop == 2'd0);
        w_drop          = w_emit && w_is_left && (w_cnt_after_pop != 2'd0);
        w_push_right    = w_emit && !w_is_left && r_left_ok;
        w_push          = w_push_left || w_push_right;
    end

    // ------------------------------------------------------------------
    // Word framing
    // ------------------------------------------------------------------
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_shreg   <= '0;
            r_count   <= '0;
            r_ws_prev <= CH_LEFT;
            r_armed   <= 1'b0;
            r_left_ok <= 1'b0;
        end else if (w_rise) begin
            if (w_edge) begin
                r_shreg   <= '0;
                r_count   <= '0;
                r_armed   <= 1'b1;
                r_ws_prev <= w_ws_s;
            end else begin
                r_shreg <= w_word;
                if (r_count < c_FULL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            // Every emitted word settles the pairing: a left word records
            // whether it got in, a right word closes the pair.
            if (w_emit) begin
                r_left_ok <= w_push_left;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {~w_is_left, w_word};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= w_cnt_after_pop + {1'b0, w_push};
        end
    end

    assign M_AXIS.TVALID = (r_fifo_cnt != 2'd0);
    assign M_AXIS.TDATA  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign M_AXIS.TLAST  = r_mem[r_rd_ptr][DATA_WIDTH];

    // ------------------------------------------------------------------
    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    // ------------------------------------------------------------------
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            overrun <= 1'b0;
        end else if (w_drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire
